// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 SEQ control path: instruction codes,
// architectural status codes and the sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPDATE,
        ST_HALT
    } state_e;

endpackage

// File: rtl/y86_icode_class.sv
// Combinational instruction classifier: which stages an icode actually uses.
module y86_icode_class
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       valid_o,
    output logic       needs_mem_o,
    output logic       writes_reg_o
);

    always_comb begin
        valid_o      = (icode_i <= IPOPQ);
        needs_mem_o  = icode_i inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
        // Stack operations write %rsp, so they count as register writers.
        writes_reg_o = icode_i inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ,
                                       ICALL, IRET, IPUSHQ, IPOPQ};
    end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle SEQ stage sequencer with status tracking and retire counter.
// Memory handshake: mem_ready is sampled only in MEMORY; mem_error is ignored unless mem_ready is high.
module y86_seq_controller
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [3:0]          icode,
    input  logic                imem_error,
    input  logic                decode_error,
    input  logic                mem_ready,
    input  logic                mem_error,
    output logic                fetch_en,
    output logic                decode_en,
    output logic                execute_en,
    output logic                memory_en,
    output logic                writeback_en,
    output logic                pcupdate_en,
    output logic [2:0]          stat,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired,
    output state_e              dbg_state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [3:0]            icode_q, icode_d;
    logic [7:0]            wait_q, wait_d;
    logic [2:0]            stat_q, stat_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic [3:0] cls_icode;
    logic       cls_valid, cls_mem, cls_wr;

    // In FETCH the live icode is classified; afterwards the captured one.
    assign cls_icode = (state_q == ST_FETCH) ? icode : icode_q;

    y86_icode_class u_class (
        .icode_i      (cls_icode),
        .valid_o      (cls_valid),
        .needs_mem_o  (cls_mem),
        .writes_reg_o (cls_wr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            icode_q   <= IHALT;
            wait_q    <= '0;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            icode_q   <= icode_d;
            wait_q    <= wait_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        wait_d    = wait_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else if (!cls_valid) begin
                    stat_d  = STAT_INS;
                    state_d = ST_HALT;
                end else if (icode == IHALT) begin
                    stat_d  = STAT_HLT;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (decode_error) begin
                    stat_d  = STAT_INS;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                wait_d = '0;
                if (cls_mem)     state_d = ST_MEMORY;
                else if (cls_wr) state_d = ST_WRITEBACK;
                else             state_d = ST_PCUPDATE;
            end
            ST_MEMORY: begin
                // A ready arriving on the final wait cycle still completes.
                if (mem_ready) begin
                    if (mem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_HALT;
                    end else begin
                        state_d = cls_wr ? ST_WRITEBACK : ST_PCUPDATE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WRITEBACK: state_d = ST_PCUPDATE;
            ST_PCUPDATE: begin
                retired_d = retired_q + 1'b1;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_en     = (state_q == ST_FETCH);
        decode_en    = (state_q == ST_DECODE);
        execute_en   = (state_q == ST_EXECUTE);
        memory_en    = (state_q == ST_MEMORY);
        writeback_en = (state_q == ST_WRITEBACK);
        pcupdate_en  = (state_q == ST_PCUPDATE);
    end

    assign stat      = stat_q;
    assign halted    = (state_q == ST_HALT);
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: doc/y86_seq_controller.md
# y86_seq_controller

Multi-cycle stage sequencer for the Y86 SEQ processor. It steps each instruction through fetch, decode, execute, memory, writeback and PC-update, one stage per cycle. It skips the memory and writeback stages when the instruction does not need them and stalls the memory stage on a ready handshake. It also maintains the architectural status code (AOK/HLT/ADR/INS) and a retired-instruction counter, and sits above the fetch, decode, ALU, data-memory and register-file blocks, driving their enables.

## Interface
- MEM_TIMEOUT, default 16: cycles MEMORY may wait for mem_ready before raising ADR; legal range 1..255.
- RETIRE_W, default 32: width of the retired-instruction counter.

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- run  in  1  level; start/continue execution
- icode  in  4  instruction code from fetch, valid during FETCH
- imem_error  in  1  fetch address invalid, valid during FETCH
- decode_error  in  1  invalid register specifier from decode, valid during DECODE
- mem_ready  in  1  data memory completed access
- mem_error  in  1  data memory address invalid, qualified by mem_ready
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupdate_en  out  1 each  one-hot stage enables
- stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4
- halted  out  1  high in HALT state
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT.
- Stage enables are Moore outputs: exactly one is high in the matching state, and all are low in IDLE and HALT.
- IDLE: go to FETCH when run=1.
- FETCH: capture icode into icode_q.
  - imem_error=1: stat<=ADR, go to HALT.
  - icode>0xB: stat<=INS, go to HALT.
  - icode==0 (halt): stat<=HLT, go to HALT.
  - Otherwise go to DECODE.
- DECODE:
  - decode_error=1: stat<=INS, go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Go to MEMORY if icode_q is one of {4,5,8,9,A,B}.
  - Otherwise go to WRITEBACK if icode_q is one of {2,3,6,8,9,A,B}.
  - Otherwise go to PCUPDATE.
- MEMORY: wait counter starts at 0 on entry and increments each cycle without mem_ready.
  - mem_ready=1 with mem_error=1: stat<=ADR, go to HALT.
  - mem_ready=1 with mem_error=0: go to WRITEBACK if icode_q writes a register, else PCUPDATE.
  - Counter reaches MEM_TIMEOUT with no ready: stat<=ADR, go to HALT.
- WRITEBACK: go to PCUPDATE.
- PCUPDATE: retired<=retired+1, wrapping modulo 2^RETIRE_W. Go to FETCH if run=1, else IDLE.
- HALT: sticky. Only reset_n leaves it; run is ignored.
- A faulting instruction does not increment retired. Halt does not increment it either.

## Timing
- Reset (reset_n=0 at a rising edge): state=IDLE, stat=AOK, halted=0, retired=0, all enables=0, wait counter=0. Applies in any state, including mid-MEMORY wait.
- Per-instruction cycles, with zero-wait memory:
  - 4 cycles: nop(1), jXX(7).
  - 5 cycles: cmov(2), irmovq(3), OPq(6), rmmovq(4).
  - 6 cycles: mrmovq(5), call(8), ret(9), pushq(A), popq(B).
  - Each cycle of memory wait adds one cycle.
- run=0 sampled in FETCH, DECODE, EXECUTE, MEMORY or WRITEBACK does not abort; the current instruction completes. run is only checked in IDLE and PCUPDATE.
- mem_ready and the timeout landing in the same cycle: mem_ready wins.
- stat and halted update on the same edge that enters HALT.

## Structure
- Package y86_pkg holds:
  - icode constants (IHALT..IPOPQ);
  - stat codes (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS);
  - the controller state enum.
- Sub-module y86_icode_class: combinational map from icode to {valid, needs_mem, writes_reg}. It is shared with the future pipelined control.
- The controller holds the FSM, the wait counter, stat and the retire counter.

## Test plan
- Reset, then run=1, icode=1 (nop) with run held: enables cycle F,D,E,P. retired=1 after 4 cycles, and FETCH is re-entered on cycle 5.
- icode=5 (mrmovq), mem_ready asserted 3 cycles after MEMORY entry, mem_error=0: path F,D,E,M(4 cycles),W,P. retired increments once, stat=AOK.
- icode=4 with mem_ready never asserted, MEM_TIMEOUT=16: after 16 MEMORY cycles go to HALT with stat=3 and halted=1. retired is unchanged, and run toggling has no effect.
- icode=0 at FETCH: HALT on the next edge, stat=2, all enables 0. icode=0xC gives stat=4. decode_error=1 on an icode=6 instruction gives stat=4 from DECODE.
- reset_n=0 during a MEMORY wait: next cycle state=IDLE, stat=1, retired=0. Also drop run during EXECUTE of icode=3: W and P still occur, then the FSM goes to IDLE.
- Retire wrap with RETIRE_W=4: 16 nops bring retired from 15 to 0, and stat stays AOK.
